// File: rtl/axi_stream_pkg.sv
// Shared defaults and beat type for the AXI-stream loopback buffer.
package axi_stream_pkg;

  localparam int T_DATA_BIT_DEF   = 128;
  localparam int T_USER_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef struct packed {
    logic [T_USER_WIDTH_DEF-1:0] user;
    logic [T_DATA_BIT_DEF-1:0]   data;
  } beat_t;

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// Dual-port beat storage: synchronous write, asynchronous read.
module axi_stream_fifo_mem #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_loopback.sv
// Stream loopback buffer: pointer/level control around a small FIFO.
module axi_stream_loopback
  import axi_stream_pkg::*;
#(
  parameter int t_data_bit   = T_DATA_BIT_DEF,
  parameter int t_user_width = T_USER_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          t_valid,
  output logic                          t_ready,
  input  logic [t_data_bit-1:0]         t_data,
  input  logic [t_user_width-1:0]       t_user,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [t_data_bit-1:0]         rx_data,
  output logic [t_user_width-1:0]       rx_user,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = t_user_width + t_data_bit;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lvl;
  logic          armed;
  logic          push;
  logic          pop;
  logic [BW-1:0] rdata;

  // armed holds t_ready low until the first edge after reset release
  assign t_ready  = armed && !flush && (lvl < LW'(FIFO_DEPTH));
  assign rx_valid = (lvl != '0);
  assign push     = t_valid && t_ready;
  assign pop      = rx_valid && rx_ready;
  assign level    = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case (1'b1)
          push && !pop: lvl <= lvl + 1'b1;
          pop && !push: lvl <= lvl - 1'b1;
          default:      lvl <= lvl;
        endcase
      end
    end
  end

  axi_stream_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({t_user, t_data}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign {rx_user, rx_data} = rdata;

endmodule

// File: tb/tb_axi_stream_loopback.sv
// Scoreboard bench for axi_stream_loopback with a queue-based reference.
module tb_axi_stream_loopback;
  import axi_stream_pkg::*;

  localparam int D = FIFO_DEPTH_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         t_valid = 1'b0;
  logic         rx_ready = 1'b0;
  logic         flush = 1'b0;
  logic [127:0] t_data = '0;
  logic [15:0]  t_user = '0;
  logic         t_ready;
  logic         rx_valid;
  logic [127:0] rx_data;
  logic [15:0]  rx_user;
  logic [2:0]   level;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_push = 0;

  always #5 clk = ~clk;

  axi_stream_loopback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .t_data   (t_data),
    .t_user   (t_user),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_user  (rx_user),
    .flush    (flush),
    .level    (level)
  );

  task automatic check(input string nm, input logic [159:0] act,
                       input logic [159:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // record the expected beat at the edge where the handshake is issued
  task automatic step();
    @(negedge clk);
    if (rst_n && t_valid && t_ready && !flush) begin
      exp_q.push_back('{user: t_user, data: t_data});
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    t_valid  = 1'b1;
    rx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      t_data = {$urandom, $urandom, $urandom, $urandom};
      t_user = 16'($urandom);
      step();
    end
    t_valid = 1'b0;
  endtask

  // monitor: level model plus pop-and-compare
  initial begin
    int          mlvl;
    bit          armed;
    bit          prev_stall;
    bit          exp_rdy;
    bit          psh;
    bit          pp;
    beat_t       b;
    logic [143:0] prev_beat;
    mlvl = 0;
    armed = 0;
    prev_stall = 0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_level", level, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_t_ready", t_ready, 0);
        exp_q.delete();
        mlvl = 0;
        armed = 0;
        prev_stall = 0;
      end else begin
        exp_rdy = armed && !flush && (mlvl < D);
        check("level", level, mlvl);
        check("t_ready", t_ready, exp_rdy);
        check("rx_valid", rx_valid, mlvl != 0);
        if (prev_stall)
          check("stall_hold", {rx_user, rx_data}, prev_beat);
        if (flush) begin
          exp_q.delete();
          mlvl = 0;
        end else begin
          pp  = (mlvl != 0) && rx_ready;
          psh = t_valid && exp_rdy;
          if (pp) begin
            if (exp_q.size() == 0) begin
              check("pop_empty_queue", exp_q.size(), 1);
            end else begin
              b = exp_q.pop_front();
              check("beat", {rx_user, rx_data}, b);
            end
          end
          mlvl = mlvl + int'(psh) - int'(pp);
        end
        prev_stall = rx_valid && !rx_ready && !flush;
        prev_beat  = {rx_user, rx_data};
        armed = 1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("ready_after_reset", t_ready, 1);

    // four beats with sink stalled, then drain
    t_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      t_data = 128'(i);
      t_user = 16'(8'hA0 + i);
      step();
    end
    t_valid = 1'b0;
    check("full_level", level, 4);
    check("full_t_ready", t_ready, 0);
    rx_ready = 1'b1;
    repeat (4) step();
    check("drained_level", level, 0);
    check("drained_rx_valid", rx_valid, 0);

    // streaming: one beat per cycle
    t_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      t_data = 128'(i + 100);
      t_user = 16'(i);
      step();
      check("stream_level", level, 1);
    end
    t_valid = 1'b0;
    step();
    check("stream_end_level", level, 0);

    // full with simultaneous valid and ready: pop only
    fill(4);
    t_valid  = 1'b1;
    rx_ready = 1'b1;
    t_data   = 128'hDEAD;
    step();
    t_valid  = 1'b0;
    rx_ready = 1'b0;
    check("full_pop_level", level, 3);
    check("full_pop_ready", t_ready, 1);
    rx_ready = 1'b1;
    repeat (4) step();

    // flush coinciding with a push
    fill(3);
    check("pre_flush_level", level, 3);
    flush   = 1'b1;
    t_valid = 1'b1;
    t_data  = 128'hBAD;
    t_user  = 16'hBAD;
    step();
    flush   = 1'b0;
    t_valid = 1'b0;
    check("flush_level", level, 0);
    check("flush_rx_valid", rx_valid, 0);
    rx_ready = 1'b1;
    repeat (2) step();

    // asynchronous reset mid-stream
    fill(2);
    check("pre_reset_level", level, 2);
    rst_n = 1'b0;
    #1;
    check("async_rx_valid", rx_valid, 0);
    check("async_t_ready", t_ready, 0);
    check("async_level", level, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_level", level, 0);
    check("post_reset_rx_valid", rx_valid, 0);

    // random traffic
    base = n_push;
    for (int c = 0; c < 60000 && (n_push - base) < 10000; c++) begin
      t_valid  = 1'($urandom_range(0, 1));
      rx_ready = 1'($urandom_range(0, 1));
      t_data   = {$urandom, $urandom, $urandom, $urandom};
      t_user   = 16'($urandom);
      step();
    end
    check("rand_beats_pushed", (n_push - base) >= 10000, 1);

    t_valid  = 1'b0;
    rx_ready = 1'b1;
    repeat (8) step();
    check("final_level", level, 0);
    check("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
